fetch_decode_front_end: RTL and testbench

Instruction-fetch and decode front end of the 5-stage ARM-subset pipeline. It holds the 8-bit program counter and its +4 adder. It latches the fetched ROM word into the IF/ID register and decodes it combinationally into ID-stage control signals. A stall/NOP select forces every control output to zero before the values enter ID/EX.

---
 rtl/fetch_decode_front_end_if.sv | 35 +++
 rtl/fetch_decode_front_end.sv | 101 ++++++++++
 tb/tb_fetch_decode_front_end.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_decode_front_end_if.sv
// Front-end bus: fetch controls and ROM word in, PC, IF/ID word and ID controls out.
// slave = front end, master = pipeline/ROM side driving LE/SS/branch/ROM.
interface fetch_decode_front_end_if;
   logic        LE;
   logic        SS;
   logic        branch_taken;
   logic [7:0]  branch_target;
   logic [31:0] rom_instruction;
   logic [7:0]  out_pc;
   logic [31:0] instruction;
   logic [3:0]  ID_opcode;
   logic        ID_AM;
   logic        ID_S_enable;
   logic        ID_load_instr;
   logic        ID_RF_enable;
   logic        ID_Size_enable;
   logic        ID_RW_enable;
   logic        ID_Enable_signal;
   logic        ID_BL_instr;
   logic        ID_B_instr;

   modport slave (
      input  LE, SS, branch_taken, branch_target, rom_instruction,
      output out_pc, instruction, ID_opcode, ID_AM, ID_S_enable,
      output ID_load_instr, ID_RF_enable, ID_Size_enable,
      output ID_RW_enable, ID_Enable_signal, ID_BL_instr, ID_B_instr
   );

   modport master (
      output LE, SS, branch_taken, branch_target, rom_instruction,
      input  out_pc, instruction, ID_opcode, ID_AM, ID_S_enable,
      input  ID_load_instr, ID_RF_enable, ID_Size_enable,
      input  ID_RW_enable, ID_Enable_signal, ID_BL_instr, ID_B_instr
   );
endinterface

// File: rtl/fetch_decode_front_end.sv
// IF/ID front end: 8-bit PC with +4/branch select, IF/ID register, ID decoder, NOP mux.
// Ports: clk, R (async active-low reset), bus (fetch_decode_front_end_if.slave).
module fetch_decode_front_end (
   input  logic                           clk,
   input  logic                           R,
   fetch_decode_front_end_if.slave        bus
);

   logic [7:0]  r_pc;
   logic [31:0] r_instr;
   logic [7:0]  w_next_pc;

   assign w_next_pc = bus.branch_taken ? bus.branch_target
                                       : r_pc + 8'd4;

   always_ff @(posedge clk or negedge R) begin
      if (!R) begin
         r_pc    <= 8'h00;
         r_instr <= 32'h0;
      end else if (bus.LE) begin
         r_pc    <= w_next_pc;
         r_instr <= bus.rom_instruction;
      end
   end

   assign bus.out_pc      = r_pc;
   assign bus.instruction = r_instr;

   logic       w_is_dp;
   logic       w_is_ls;
   logic       w_is_br;
   logic [3:0] w_opcode;
   logic       w_am;
   logic       w_s;
   logic       w_ld;
   logic       w_rf;
   logic       w_sz;
   logic       w_rw;
   logic       w_en;
   logic       w_bl;
   logic       w_b;

   // An all-zero word would otherwise decode as AND with RF write.
   assign w_is_dp = (r_instr[27:26] == 2'b00) && (|r_instr);
   assign w_is_ls = (r_instr[27:26] == 2'b01);
   assign w_is_br = (r_instr[27:25] == 3'b101);

   always_comb begin
      w_opcode = 4'h0;
      w_am     = 1'b0;
      w_s      = 1'b0;
      w_ld     = 1'b0;
      w_rf     = 1'b0;
      w_sz     = 1'b0;
      w_rw     = 1'b0;
      w_en     = 1'b0;
      w_bl     = 1'b0;
      w_b      = 1'b0;
      unique case (1'b1)
         w_is_dp: begin
            w_opcode = r_instr[24:21];
            w_s      = r_instr[20];
            w_am     = r_instr[25];
            // TST/TEQ/CMP/CMN only set flags
            w_rf     = (r_instr[24:23] != 2'b10);
         end
         w_is_ls: begin
            w_am     = ~r_instr[25];
            w_opcode = r_instr[23] ? 4'b0100 : 4'b0010;
            w_sz     = r_instr[22];
            w_ld     = r_instr[20];
            w_rf     = r_instr[20];
            w_rw     = ~r_instr[20];
            w_en     = 1'b1;
         end
         w_is_br: begin
            w_b      = 1'b1;
            w_bl     = r_instr[24];
            w_rf     = r_instr[24];
         end
         default: begin
            w_opcode = 4'h0;
         end
      endcase
   end

   logic w_pass;
   assign w_pass = ~bus.SS;

   assign bus.ID_opcode        = w_pass ? w_opcode : 4'h0;
   assign bus.ID_AM            = w_pass & w_am;
   assign bus.ID_S_enable      = w_pass & w_s;
   assign bus.ID_load_instr    = w_pass & w_ld;
   assign bus.ID_RF_enable     = w_pass & w_rf;
   assign bus.ID_Size_enable   = w_pass & w_sz;
   assign bus.ID_RW_enable     = w_pass & w_rw;
   assign bus.ID_Enable_signal = w_pass & w_en;
   assign bus.ID_BL_instr      = w_pass & w_bl;
   assign bus.ID_B_instr       = w_pass & w_b;

endmodule

// File: tb/tb_fetch_decode_front_end.sv
// Bench for fetch_decode_front_end: directed steps then random cycles vs a reference model.
// Ports: none; drives the DUT through a fetch_decode_front_end_if instance.
module tb_fetch_decode_front_end;

   logic clk;
   logic R;
   int   total;
   int   bad;

   logic [7:0]  m_pc;
   logic [31:0] m_ir;

   fetch_decode_front_end_if bus ();

   fetch_decode_front_end dut (
      .clk (clk),
      .R   (R),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [12:0] ref_dec(input logic [31:0] w,
                                           input logic ss);
      logic [3:0] op;
      logic am, s, ld, rf, sz, rw, en, bl, b;
      op = 4'h0;
      {am, s, ld, rf, sz, rw, en, bl, b} = 9'h0;
      if (!ss && w != 32'h0) begin
         if (w[27:26] == 2'b00) begin
            op = w[24:21];
            s  = w[20];
            am = w[25];
            rf = !(op >= 4'd8 && op <= 4'd11);
         end else if (w[27:26] == 2'b01) begin
            am = !w[25];
            op = w[23] ? 4'd4 : 4'd2;
            sz = w[22];
            ld = w[20];
            rf = w[20];
            rw = !w[20];
            en = 1'b1;
         end else if (w[27:25] == 3'b101) begin
            b  = 1'b1;
            bl = w[24];
            rf = w[24];
         end
      end
      return {op, am, s, ld, rf, sz, rw, en, bl, b};
   endfunction

   function automatic logic [12:0] dut_ctrl();
      return {bus.ID_opcode, bus.ID_AM, bus.ID_S_enable,
              bus.ID_load_instr, bus.ID_RF_enable, bus.ID_Size_enable,
              bus.ID_RW_enable, bus.ID_Enable_signal, bus.ID_BL_instr,
              bus.ID_B_instr};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".pc"}, {24'h0, bus.out_pc}, {24'h0, m_pc});
      check({tag, ".ir"}, bus.instruction, m_ir);
      check({tag, ".ctl"}, {19'h0, dut_ctrl()},
            {19'h0, ref_dec(m_ir, bus.SS)});
   endtask

   // One clock edge with the model advanced from the same inputs.
   task automatic step(input string tag);
      @(posedge clk);
      if (bus.LE) begin
         m_pc = bus.branch_taken ? bus.branch_target : m_pc + 8'd4;
         m_ir = bus.rom_instruction;
      end
      #1;
      check_all(tag);
   endtask

   task automatic load(input logic [31:0] w, input string tag);
      bus.LE = 1'b1;
      bus.branch_taken = 1'b0;
      bus.rom_instruction = w;
      step(tag);
   endtask

   logic [31:0] pool [8];

   initial begin
      total = 0;
      bad = 0;
      pool[0] = 32'hE2910003;
      pool[1] = 32'hE1500001;
      pool[2] = 32'hE59F1008;
      pool[3] = 32'hE5432001;
      pool[4] = 32'hEB000004;
      pool[5] = 32'hEA000004;
      pool[6] = 32'h00000000;
      pool[7] = 32'hEC000000;

      bus.LE = 1'b0;
      bus.SS = 1'b0;
      bus.branch_taken = 1'b0;
      bus.branch_target = 8'h00;
      bus.rom_instruction = 32'h0;
      R = 1'b1;
      #3 R = 1'b0;
      #1;
      m_pc = 8'h00;
      m_ir = 32'h0;
      check("rst.pc", {24'h0, bus.out_pc}, 32'h0);
      check("rst.ir", bus.instruction, 32'h0);
      check("rst.ctl", {19'h0, dut_ctrl()}, 32'h0);

      @(negedge clk);
      R = 1'b1;
      bus.LE = 1'b1;
      step("inc1");
      check("inc1.c", {24'h0, bus.out_pc}, 32'h04);
      step("inc2");
      step("inc3");
      check("inc3.c", {24'h0, bus.out_pc}, 32'h0C);
      bus.LE = 1'b0;
      step("hold1");
      step("hold2");
      check("hold.c", {24'h0, bus.out_pc}, 32'h0C);

      bus.LE = 1'b1;
      bus.branch_taken = 1'b1;
      bus.branch_target = 8'hFC;
      step("to_fc");
      bus.branch_taken = 1'b0;
      step("wrap");
      check("wrap.c", {24'h0, bus.out_pc}, 32'h00);
      bus.branch_taken = 1'b1;
      bus.branch_target = 8'h40;
      step("br40");
      check("br40.c", {24'h0, bus.out_pc}, 32'h40);
      bus.LE = 1'b0;
      bus.branch_target = 8'h80;
      step("brhold");
      check("brhold.c", {24'h0, bus.out_pc}, 32'h40);

      load(32'hE1500001, "cmp");
      check("cmp.c", {19'h0, dut_ctrl()}, {19'h0, 13'b1010_0_1_0_0_0_0_0_0_0});
      load(32'hE59F1008, "ldr");
      check("ldr.c", {19'h0, dut_ctrl()}, {19'h0, 13'b0100_1_0_1_1_0_0_1_0_0});
      load(32'hE5432001, "strb");
      check("strb.c", {19'h0, dut_ctrl()}, {19'h0, 13'b0010_1_0_0_0_1_1_1_0_0});
      load(32'hEB000004, "bl");
      check("bl.c", {19'h0, dut_ctrl()}, {19'h0, 13'b0000_0_0_0_1_0_0_0_1_1});
      load(32'hEA000004, "b");
      check("b.c", {19'h0, dut_ctrl()}, {19'h0, 13'b0000_0_0_0_0_0_0_0_0_1});
      load(32'hE2910003, "adds");
      check("adds.c", {19'h0, dut_ctrl()}, {19'h0, 13'b0100_1_1_0_1_0_0_0_0_0});

      bus.LE = 1'b0;
      bus.SS = 1'b1;
      #1;
      check("nop.ctl", {19'h0, dut_ctrl()}, 32'h0);
      check("nop.ir", bus.instruction, 32'hE2910003);
      bus.SS = 1'b0;
      #1;
      check("unnop.c", {19'h0, dut_ctrl()}, {19'h0, 13'b0100_1_1_0_1_0_0_0_0_0});

      @(negedge clk);
      #2 R = 1'b0;
      #1;
      m_pc = 8'h00;
      m_ir = 32'h0;
      check_all("arst");
      @(negedge clk);
      R = 1'b1;

      for (int i = 0; i < 400; i++) begin
         bus.LE = ($urandom_range(0, 3) != 0);
         bus.SS = ($urandom_range(0, 4) == 0);
         bus.branch_taken = ($urandom_range(0, 3) == 0);
         bus.branch_target = 8'($urandom);
         if ($urandom_range(0, 1) == 0)
            bus.rom_instruction = pool[$urandom_range(0, 7)];
         else
            bus.rom_instruction = $urandom;
         #1;
         check("rnd.comb", {19'h0, dut_ctrl()},
               {19'h0, ref_dec(m_ir, bus.SS)});
         step("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
